// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous memory between fetch and data requesters.
// Optional perf counters are enabled with `define MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          stall
`ifdef MEM_PORT_ARBITER_PERF_EN
   ,
   output logic [31:0]   perf_if_grants,
   output logic [31:0]   perf_d_grants,
   output logic [31:0]   perf_conflicts
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t     state;
   logic       owner_if;
   logic [2:0] lat_cnt;
   logic [3:0] starve_cnt;
   logic       both;
   logic       fetch_win;

   assign both      = if_req & d_req;
   assign fetch_win = if_req & (~d_req | (starve_cnt == 4'(STARVE_LIMIT)));
   assign stall     = (if_req & ~if_ack) | (d_req & ~d_ack);

   // Reads always spend MEM_LAT cycles in WAIT so the registered memory output is valid when captured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner_if   <= 1'b0;
         lat_cnt    <= '0;
         starve_cnt <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_ack     <= 1'b0;
         d_ack      <= 1'b0;
         if_rdata   <= '0;
         d_rdata    <= '0;
      end else begin
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         case (state)
            IDLE: begin
               if (if_req | d_req) begin
                  owner_if <= fetch_win;
                  mem_en   <= 1'b1;
                  if (fetch_win) begin
                     mem_we     <= 1'b0;
                     mem_addr   <= if_addr;
                     starve_cnt <= '0;
                  end else begin
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     if (both && starve_cnt != 4'(STARVE_LIMIT))
                        starve_cnt <= starve_cnt + 4'd1;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_we) begin
                  if_ack <= owner_if;
                  d_ack  <= ~owner_if;
                  state  <= DONE;
               end else begin
                  lat_cnt <= 3'(MEM_LAT - 1);
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (lat_cnt == 3'd0) begin
                  if (owner_if) if_rdata <= mem_rdata;
                  else          d_rdata  <= mem_rdata;
                  if_ack <= owner_if;
                  d_ack  <= ~owner_if;
                  state  <= DONE;
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_PORT_ARBITER_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_if_grants <= '0;
         perf_d_grants  <= '0;
         perf_conflicts <= '0;
      end else begin
         if (state == DONE && owner_if && perf_if_grants != '1)
            perf_if_grants <= perf_if_grants + 32'd1;
         if (state == DONE && !owner_if && perf_d_grants != '1)
            perf_d_grants <= perf_d_grants + 32'd1;
         if (state == IDLE && both && perf_conflicts != '1)
            perf_conflicts <= perf_conflicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one MEM_LAT=1 instance with a small RAM model,
// one MEM_LAT=4 instance with an address-derived read pattern.
module tb_mem_port_arbiter;
   logic        clk;
   int          total, bad;

   logic        rst, if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, stall;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        b_rst, b_if_req, b_if_ack, b_d_req, b_d_we, b_d_ack, b_mem_en, b_mem_we, b_stall;
   logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
`ifdef MEM_PORT_ARBITER_PERF_EN
   logic [31:0] perf_if_grants, perf_d_grants, perf_conflicts;
   logic [31:0] b_perf_if_grants, b_perf_d_grants, b_perf_conflicts;
`endif

   logic        pl_en;
   logic [7:0]  pl_addr;
   logic [31:0] pl_data;
   logic [31:0] mem_a [0:255];
   logic [31:0] rd_a;
   logic [31:0] pb [0:3];

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_LIMIT(3)) dut_a (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall(stall)
`ifdef MEM_PORT_ARBITER_PERF_EN
      , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants), .perf_conflicts(perf_conflicts)
`endif
   );

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(4), .STARVE_LIMIT(3)) dut_b (
      .clk(clk), .rst(b_rst), .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
      .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_ack(b_d_ack), .d_rdata(b_d_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .stall(b_stall)
`ifdef MEM_PORT_ARBITER_PERF_EN
      , .perf_if_grants(b_perf_if_grants), .perf_d_grants(b_perf_d_grants), .perf_conflicts(b_perf_conflicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle-latency RAM for instance A, with a backdoor preload port.
   always @(posedge clk) begin
      if (pl_en) mem_a[pl_addr] <= pl_data;
      else if (mem_en && mem_we) mem_a[mem_addr[9:2]] <= mem_wdata;
      if (mem_en && !mem_we) rd_a <= mem_a[mem_addr[9:2]];
   end
   assign mem_rdata = rd_a;

   // Four-cycle read pipe for instance B; read data = addr ^ 0xCAFE0000.
   always @(posedge clk) begin
      if (b_mem_en && !b_mem_we) pb[0] <= b_mem_addr ^ 32'hCAFE_0000;
      pb[1] <= pb[0];
      pb[2] <= pb[1];
      pb[3] <= pb[2];
   end
   assign b_mem_rdata = pb[3];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] v);
      pl_en = 1'b1; pl_addr = a; pl_data = v;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic xfer(input logic fi, input logic fd, input logic [31:0] ia, input logic [31:0] da,
                       input logic we, input logic [31:0] wd, output int cyc);
      if_req = fi; if_addr = ia; d_req = fd; d_addr = da; d_we = we; d_wdata = wd;
      cyc = 0;
      while ((if_req || d_req) && cyc < 40) begin
         tick(); cyc++;
         if (if_ack) if_req = 1'b0;
         if (d_ack) d_req = 1'b0;
      end
      if_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_reset;
      total++; if ({mem_en, mem_we, if_ack, d_ack} !== 4'b0) begin bad++; $display("FAIL rst_ctrl got %b want 0000", {mem_en, mem_we, if_ack, d_ack}); end
      total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem got %h/%h want 0/0", mem_addr, mem_wdata); end
      total++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got %h/%h want 0/0", if_rdata, d_rdata); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall_idle got %b want 0", stall); end
      if_req = 1'b1; #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_stall_req got %b want 1", stall); end
      tick();
      total++; if (mem_en !== 1'b0 || if_ack !== 1'b0) begin bad++; $display("FAIL rst_hold got en=%b ack=%b want 0/0", mem_en, if_ack); end
      if_req = 1'b0;
      rst = 1'b0; b_rst = 1'b0;
      tick();
   endtask

   task automatic test_fetch_read;
      if_req = 1'b1; if_addr = 32'h40; #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL fetch_stall_t0 got %b want 1", stall); end
      tick();
      total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin bad++; $display("FAIL fetch_issue got en=%b we=%b a=%h want 1/0/40", mem_en, mem_we, mem_addr); end
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL fetch_stall_t1 got %b want 1", stall); end
      tick();
      total++; if (mem_en !== 1'b0 || if_ack !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL fetch_t2 got en=%b ack=%b stall=%b want 0/0/1", mem_en, if_ack, stall); end
      tick();
      total++; if (if_ack !== 1'b1 || d_ack !== 1'b0) begin bad++; $display("FAIL fetch_ack got if=%b d=%b want 1/0", if_ack, d_ack); end
      total++; if (if_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fetch_rdata got %h want deadbeef", if_rdata); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL fetch_stall_t3 got %b want 0", stall); end
      if_req = 1'b0;
      tick();
      total++; if (if_ack !== 1'b0) begin bad++; $display("FAIL fetch_ack_pulse got %b want 0", if_ack); end
   endtask

   task automatic test_store_load;
      int n;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234_5678;
      tick();
      total++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'h1234_5678) begin
         bad++; $display("FAIL store_issue got en=%b we=%b a=%h d=%h want 1/1/100/12345678", mem_en, mem_we, mem_addr, mem_wdata); end
      tick();
      total++; if (d_ack !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL store_ack got ack=%b we=%b want 1/0", d_ack, mem_we); end
      d_req = 1'b0;
      tick();
      d_req = 1'b1; d_we = 1'b0;
      n = 0;
      while (!d_ack && n < 20) begin tick(); n++; end
      total++; if (n !== 3) begin bad++; $display("FAIL load_latency got %0d want 3", n); end
      total++; if (d_rdata !== 32'h1234_5678) begin bad++; $display("FAIL load_rdata got %h want 12345678", d_rdata); end
      d_req = 1'b0;
      tick();
   endtask

   task automatic test_conflict;
      if_req = 1'b1; if_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
      tick();
      total++; if (mem_addr !== 32'h8) begin bad++; $display("FAIL conflict_first got %h want 8", mem_addr); end
      tick(); tick();
      total++; if (d_ack !== 1'b1 || if_ack !== 1'b0 || d_rdata !== 32'h5555_0008) begin
         bad++; $display("FAIL conflict_d_ack got d=%b if=%b rd=%h want 1/0/55550008", d_ack, if_ack, d_rdata); end
      d_req = 1'b0;
      tick(); tick();
      total++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin bad++; $display("FAIL conflict_second got en=%b a=%h want 1/40", mem_en, mem_addr); end
      tick(); tick();
      total++; if (if_ack !== 1'b1 || if_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL conflict_if_ack got %b/%h want 1/deadbeef", if_ack, if_rdata); end
      total++; if (dut_a.starve_cnt !== 4'd0) begin bad++; $display("FAIL conflict_starve_clr got %0d want 0", dut_a.starve_cnt); end
      if_req = 1'b0;
   endtask

   task automatic test_starve;
      logic [3:0] order;
      int ng, cyc;
      order = 4'b0; ng = 0; cyc = 0;
      if_req = 1'b1; if_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hA0A0_0001;
      while (ng < 4 && cyc < 60) begin
         tick(); cyc++;
         if (d_ack) begin order[ng] = 1'b0; ng++; d_addr = d_addr + 32'd4; d_wdata = d_wdata + 32'd1; end
         if (if_ack && ng < 4) begin order[ng] = 1'b1; ng++; if_req = 1'b0; end
      end
      if_req = 1'b0; d_req = 1'b0;
      total++; if (ng !== 4) begin bad++; $display("FAIL starve_grants got %0d want 4", ng); end
      total++; if (order !== 4'b1000) begin bad++; $display("FAIL starve_order got %b want 1000", order); end
      tick();
   endtask

   task automatic test_reset_wait;
      int n;
      b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h20;
      tick();
      total++; if (b_mem_en !== 1'b1 || b_mem_addr !== 32'h20) begin bad++; $display("FAIL rw_issue got en=%b a=%h want 1/20", b_mem_en, b_mem_addr); end
      tick();
      #1 b_rst = 1'b1;
      #1;
      total++; if ({b_mem_en, b_mem_we, b_d_ack, b_if_ack} !== 4'b0 || b_mem_addr !== 32'h0) begin
         bad++; $display("FAIL rw_async got ctl=%b a=%h want 0000/0", {b_mem_en, b_mem_we, b_d_ack, b_if_ack}, b_mem_addr); end
      total++; if (b_d_rdata !== 32'h0 || b_stall !== 1'b1) begin bad++; $display("FAIL rw_out got rd=%h stall=%b want 0/1", b_d_rdata, b_stall); end
      n = 0;
      tick(); if (b_d_ack) n++;
      tick(); if (b_d_ack) n++;
      total++; if (n !== 0) begin bad++; $display("FAIL rw_no_ack got %0d acks want 0", n); end
      b_rst = 1'b0;
      n = 0;
      while (!b_d_ack && n < 20) begin tick(); n++; end
      total++; if (n !== 6) begin bad++; $display("FAIL rw_latency got %0d want 6", n); end
      total++; if (b_d_rdata !== 32'hCAFE_0020) begin bad++; $display("FAIL rw_rdata got %h want cafe0020", b_d_rdata); end
      b_d_req = 1'b0;
      tick();
   endtask

`ifdef MEM_PORT_ARBITER_PERF_EN
   task automatic test_perf;
      int c, worst;
      rst = 1'b1; tick(); rst = 1'b0;
      total++; if ({perf_if_grants, perf_d_grants, perf_conflicts} !== 96'h0) begin bad++; $display("FAIL perf_reset got %0d/%0d/%0d want 0/0/0", perf_if_grants, perf_d_grants, perf_conflicts); end
      worst = 0;
      xfer(1'b1, 1'b1, 32'h40, 32'h300, 1'b1, 32'h1, c); if (c > worst) worst = c;
      xfer(1'b1, 1'b1, 32'h44, 32'h304, 1'b1, 32'h2, c); if (c > worst) worst = c;
      for (int i = 0; i < 3; i++) begin xfer(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, c); if (c > worst) worst = c; end
      xfer(1'b0, 1'b1, 32'h0, 32'h308, 1'b1, 32'h3, c); if (c > worst) worst = c;
      tick();
      total++; if (worst >= 40) begin bad++; $display("FAIL perf_timeout got %0d cycles want <40", worst); end
      total++; if (perf_if_grants !== 32'd5) begin bad++; $display("FAIL perf_if got %0d want 5", perf_if_grants); end
      total++; if (perf_d_grants !== 32'd3) begin bad++; $display("FAIL perf_d got %0d want 3", perf_d_grants); end
      total++; if (perf_conflicts !== 32'd2) begin bad++; $display("FAIL perf_conf got %0d want 2", perf_conflicts); end
   endtask
`endif

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; b_rst = 1'b1;
      if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      tick();
      preload(8'h10, 32'hDEAD_BEEF);
      preload(8'h02, 32'h5555_0008);
      test_reset();
      test_fetch_read();
      test_store_load();
      test_conflict();
      test_starve();
      test_reset_wait();
`ifdef MEM_PORT_ARBITER_PERF_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
